route_dispatcher: RTL and testbench

- Sits directly downstream of the per-node receiver queue.
- Consumes its selected message, write-enable alert and 2-bit source code, and buffers messages in a small FIFO.
- Decodes each message's destination node ID and hop budget, then forwards it to the left link, right link or local (self) port over a valid/ready handshake.
- Messages whose hop budget is exhausted are dropped.

---
 rtl/route_dispatcher_if.sv | 33 +++
 rtl/route_dispatcher.sv | 195 +++++++++++++++++++
 tb/tb_route_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_dispatcher_if.sv
// Bus bundle between the receiver queue, the route dispatcher and the three
// downstream consumers (left link, right link, local port).
interface route_dispatcher_if #(
    parameter int width = 32
);
    logic             wr_en;
    logic [1:0]       src;
    logic [width-1:0] in_msg;
    logic [width-1:0] out_msg;
    logic             out_valid_l;
    logic             out_valid_r;
    logic             out_valid_s;
    logic             ready_l;
    logic             ready_r;
    logic             ready_s;
    logic             full;
    logic             overflow;
    logic             drop;

    // Dispatcher side
    modport slave (
        input  wr_en, src, in_msg, ready_l, ready_r, ready_s,
        output out_msg, out_valid_l, out_valid_r, out_valid_s,
        output full, overflow, drop
    );

    // Environment side: receiver plus consumers
    modport master (
        output wr_en, src, in_msg, ready_l, ready_r, ready_s,
        input  out_msg, out_valid_l, out_valid_r, out_valid_s,
        input  full, overflow, drop
    );
endinterface

// File: rtl/route_dispatcher.sv
// Route dispatcher: buffers {src, msg} from the receiver in a small FIFO and
// forwards each head message to the left, right or local port over
// valid/ready, decrementing TTL on forwarded hops and dropping expired or
// reserved-source messages.
// Optional: define ROUTE_DISPATCH_STATS_EN to add saturating drop/overflow
// counters (drop_cnt, ovf_cnt).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | output stage empty; pops and decodes head when FIFO non-empty
// HOLD  | out_msg and one out_valid_* held until the selected ready
module route_dispatcher #(
    parameter int         width   = 32,
    parameter logic [3:0] NODE_ID = 4'd0,
    parameter int         DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    route_dispatcher_if.slave bus
`ifdef ROUTE_DISPATCH_STATS_EN
    ,
    output logic [15:0]    drop_cnt,
    output logic [15:0]    ovf_cnt
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [width+1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    state_t           state_q, state_n;
    logic [width-1:0] out_msg_q, out_msg_n;
    logic             valid_l_q, valid_l_n;
    logic             valid_r_q, valid_r_n;
    logic             valid_s_q, valid_s_n;
    logic             drop_q, drop_n;
    logic             ovf_q;

    logic [1:0]       head_src;
    logic [width-1:0] head_msg;
    logic [width-1:0] fwd_msg;
    logic [3:0]       head_dest;
    logic [3:0]       head_ttl;
    logic             accept;
    logic             take;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a write.
    assign push       = bus.wr_en && !fifo_full;

    assign {head_src, head_msg} = mem[rd_ptr];
    assign head_dest = head_msg[width-1 -: 4];
    assign head_ttl  = head_msg[width-5 -: 4];

    assign accept = (valid_l_q && bus.ready_l) ||
                    (valid_r_q && bus.ready_r) ||
                    (valid_s_q && bus.ready_s);

    // Forwarded copy of the head with the TTL field reduced by one hop
    always_comb begin
        fwd_msg = head_msg;
        fwd_msg[width-5 -: 4] = head_ttl - 4'd1;
    end

    // FIFO storage; contents are don't-care while count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.src, bus.in_msg};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output-stage state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            out_msg_q <= '0;
            valid_l_q <= 1'b0;
            valid_r_q <= 1'b0;
            valid_s_q <= 1'b0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            out_msg_q <= out_msg_n;
            valid_l_q <= valid_l_n;
            valid_r_q <= valid_r_n;
            valid_s_q <= valid_s_n;
            drop_q    <= drop_n;
            ovf_q     <= bus.wr_en && fifo_full;
        end
    end

    // Next state: pop when the output stage is free (or freed this edge)
    // and route the head by source, destination and TTL
    always_comb begin
        state_n   = state_q;
        out_msg_n = out_msg_q;
        valid_l_n = valid_l_q;
        valid_r_n = valid_r_q;
        valid_s_n = valid_s_q;
        drop_n    = 1'b0;
        take      = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                take = !fifo_empty;
            end
            HOLD: begin
                if (accept) begin
                    valid_l_n = 1'b0;
                    valid_r_n = 1'b0;
                    valid_s_n = 1'b0;
                    state_n   = IDLE;
                    take      = !fifo_empty;
                end
            end
            default: state_n = IDLE;
        endcase

        if (take) begin
            pop = 1'b1;
            if (head_src == 2'b11) begin
                drop_n  = 1'b1;
                state_n = IDLE;
            end else if (head_dest == NODE_ID) begin
                out_msg_n = head_msg;
                valid_s_n = 1'b1;
                state_n   = HOLD;
            end else if (head_ttl == 4'd0) begin
                drop_n  = 1'b1;
                state_n = IDLE;
            end else if (head_dest > NODE_ID) begin
                out_msg_n = fwd_msg;
                valid_r_n = 1'b1;
                state_n   = HOLD;
            end else begin
                out_msg_n = fwd_msg;
                valid_l_n = 1'b1;
                state_n   = HOLD;
            end
        end
    end

    assign bus.out_msg     = out_msg_q;
    assign bus.out_valid_l = valid_l_q;
    assign bus.out_valid_r = valid_r_q;
    assign bus.out_valid_s = valid_s_q;
    assign bus.full        = fifo_full;
    assign bus.overflow    = ovf_q;
    assign bus.drop        = drop_q;

`ifdef ROUTE_DISPATCH_STATS_EN
    // Saturating event counters driven by the registered pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop_q && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (ovf_q && ovf_cnt != 16'hFFFF)   ovf_cnt  <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_route_dispatcher.sv
// Bench for route_dispatcher (NODE_ID=5, DEPTH=4): directed scenarios plus
// randomized bursts, with delivered/dropped messages compared in order
// against a transaction-level routing model.
module tb_route_dispatcher;

    localparam int         W     = 32;
    localparam logic [3:0] NODE  = 4'd5;
    localparam int         DEPTH = 4;

    logic clk;
    logic reset;

    route_dispatcher_if #(.width(W)) bus ();

`ifdef ROUTE_DISPATCH_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] ovf_cnt;
`endif

    route_dispatcher #(
        .width   (W),
        .NODE_ID (NODE),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef ROUTE_DISPATCH_STATS_EN
        ,
        .drop_cnt (drop_cnt),
        .ovf_cnt  (ovf_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Events: {port, msg}; port 0 = dropped, 1 = left, 2 = right, 3 = self
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];

    function automatic logic [31:0] mk(input int dest, input int ttl, input int payload);
        return (32'(dest) << 28) | (32'(ttl) << 24) | (32'(payload) & 32'h00FF_FFFF);
    endfunction

    // Routing rules applied to one message, independent of timing
    function automatic logic [33:0] model_route(input logic [1:0] s, input logic [31:0] m);
        int dest;
        int ttl;
        dest = int'(m >> 28);
        ttl  = int'((m >> 24) & 32'hF);
        if (s == 2'b11)       return {2'd0, 32'd0};
        if (dest == int'(NODE)) return {2'd3, m};
        if (ttl == 0)         return {2'd0, 32'd0};
        if (dest > int'(NODE)) return {2'd2, m - 32'h0100_0000};
        return {2'd1, m - 32'h0100_0000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record a handshake completing at this edge, then the
    // post-edge drop pulse, and check the valids stay one-hot.
    task automatic step();
        if (bus.out_valid_l && bus.ready_l) obs_q.push_back({2'd1, bus.out_msg});
        if (bus.out_valid_r && bus.ready_r) obs_q.push_back({2'd2, bus.out_msg});
        if (bus.out_valid_s && bus.ready_s) obs_q.push_back({2'd3, bus.out_msg});
        @(posedge clk);
        #1;
        if (bus.drop) obs_q.push_back({2'd0, 32'd0});
        chk("onehot", 64'($countones({bus.out_valid_l, bus.out_valid_r, bus.out_valid_s}) <= 1), 64'd1);
    endtask

    task automatic set_ready(input logic l, input logic r, input logic s);
        bus.ready_l = l;
        bus.ready_r = r;
        bus.ready_s = s;
    endtask

    task automatic rand_ready();
        set_ready(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drive_write(input logic [1:0] s, input logic [31:0] m);
        bus.wr_en  = 1'b1;
        bus.src    = s;
        bus.in_msg = m;
        step();
        bus.wr_en  = 1'b0;
    endtask

    task automatic drain(input int n, input int budget, input bit rnd, output int used);
        used = 0;
        while (obs_q.size() < n && used < budget) begin
            if (rnd) rand_ready();
            step();
            used++;
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ev%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] msgs[6];
        logic [1:0]  s;
        int          used;
        int          nb;
        int          total;

        reset      = 1'b1;
        bus.wr_en  = 1'b0;
        bus.src    = 2'b00;
        bus.in_msg = '0;
        set_ready(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'({bus.out_valid_l, bus.out_valid_r, bus.out_valid_s}), 64'd0);
        chk("rst_out_msg", 64'(bus.out_msg), 64'd0);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_drop", 64'(bus.drop), 64'd0);
        reset = 1'b0;
        step();

        // Local delivery, TTL ignored; latency of one edge after the write
        set_ready(1'b0, 1'b0, 1'b1);
        m = mk(5, 0, 24'hABCDEF);
        exp_q.push_back(model_route(2'b01, m));
        drive_write(2'b01, m);
        chk("lat_before", 64'(bus.out_valid_s), 64'd0);
        step();
        chk("self_valid", 64'(bus.out_valid_s), 64'd1);
        chk("self_msg", 64'(bus.out_msg), 64'(m));
        chk("self_lr_low", 64'({bus.out_valid_l, bus.out_valid_r}), 64'd0);
        step();
        step();
        compare_events("self");

        // Right then left forwarding with TTL decrement
        set_ready(1'b1, 1'b1, 1'b1);
        m = mk(9, 3, 24'h111111);
        exp_q.push_back(model_route(2'b00, m));
        drive_write(2'b00, m);
        step();
        chk("right_valid", 64'(bus.out_valid_r), 64'd1);
        chk("right_ttl", 64'(bus.out_msg[27:24]), 64'd2);
        m = mk(2, 1, 24'h222222);
        exp_q.push_back(model_route(2'b10, m));
        drive_write(2'b10, m);
        step();
        chk("left_valid", 64'(bus.out_valid_l), 64'd1);
        chk("left_ttl", 64'(bus.out_msg[27:24]), 64'd0);
        step();
        compare_events("fwd");

        // Expired TTL and reserved source are dropped with one-cycle pulses
        m = mk(9, 0, 24'h333333);
        exp_q.push_back(model_route(2'b00, m));
        drive_write(2'b00, m);
        step();
        chk("drop_ttl_pulse", 64'(bus.drop), 64'd1);
        step();
        chk("drop_ttl_end", 64'(bus.drop), 64'd0);
        chk("drop_no_valid", 64'({bus.out_valid_l, bus.out_valid_r, bus.out_valid_s}), 64'd0);
        m = mk(5, 2, 24'h444444);
        exp_q.push_back(model_route(2'b11, m));
        drive_write(2'b11, m);
        step();
        chk("drop_src11", 64'(bus.drop), 64'd1);
        step();
        compare_events("drop");

        // Fill with the right port stalled, then overflow, incl. full+pop
        set_ready(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) msgs[i] = mk(9, 3, 24'h500000 + i);
        for (int i = 0; i < 5; i++) exp_q.push_back(model_route(2'b00, msgs[i]));
        for (int i = 0; i < 5; i++) begin
            bus.wr_en  = 1'b1;
            bus.src    = 2'b00;
            bus.in_msg = msgs[i];
            step();
        end
        bus.wr_en = 1'b0;
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_hold_r", 64'(bus.out_valid_r), 64'd1);
        chk("fill_no_ovf", 64'(bus.overflow), 64'd0);
        drive_write(2'b00, msgs[5]);
        chk("ovf_pulse", 64'(bus.overflow), 64'd1);
        chk("ovf_full", 64'(bus.full), 64'd1);
        step();
        chk("ovf_end", 64'(bus.overflow), 64'd0);
        set_ready(1'b0, 1'b1, 1'b0);
        drive_write(2'b00, mk(9, 3, 24'h5FFFFF));
        chk("ovf_full_pop", 64'(bus.overflow), 64'd1);
        drain(5, 40, 1'b0, used);
        chk("drain_cycles", 64'(used), 64'd4);
        step();
        step();
        compare_events("fill");

        // Back-to-back alternating right/left with all consumers ready
        set_ready(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            m = mk((i % 2 == 0) ? 9 : 2, 2, 24'h600000 + i);
            exp_q.push_back(model_route(2'b01, m));
            bus.wr_en  = 1'b1;
            bus.src    = 2'b01;
            bus.in_msg = m;
            step();
        end
        bus.wr_en = 1'b0;
        drain(4, 40, 1'b0, used);
        chk("b2b_cycles", 64'(used), 64'd2);
        compare_events("b2b");

        // Reset in HOLD with two buffered entries, then a clean delivery
        set_ready(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.wr_en  = 1'b1;
            bus.src    = 2'b00;
            bus.in_msg = mk(9, 3, 24'h700000 + i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("pre_rst_hold", 64'(bus.out_valid_r), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'({bus.out_valid_l, bus.out_valid_r, bus.out_valid_s}), 64'd0);
        chk("async_rst_full", 64'(bus.full), 64'd0);
        chk("async_rst_msg", 64'(bus.out_msg), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        set_ready(1'b1, 1'b1, 1'b1);
        m = mk(5, 1, 24'h7ABCDE);
        exp_q.push_back(model_route(2'b01, m));
        drive_write(2'b01, m);
        drain(1, 20, 1'b0, used);
        repeat (4) step();
        compare_events("post_rst");

        // Randomized bursts with random consumer stalls
        total = 0;
        for (int it = 0; it < 30; it++) begin
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                s = 2'($urandom_range(0, 3));
                m = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom);
                exp_q.push_back(model_route(s, m));
                rand_ready();
                bus.wr_en  = 1'b1;
                bus.src    = s;
                bus.in_msg = m;
                step();
            end
            bus.wr_en = 1'b0;
            total += nb;
            drain(exp_q.size(), 200, 1'b1, used);
            compare_events($sformatf("rnd%0d", it));
        end
        chk("rnd_no_overflow", 64'(bus.overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
